// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the core control FSM and the iterative
// multiplier. The requester pulses start with its operands; the sequencer
// reports busy, a one-cycle done pulse, the product halves, the {N,Z} flags
// and its FSM state for debug.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             is_long;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [1:0]       mul_nz;
    logic [1:0]       state;

    // Handshake: start is sampled only while the sequencer is idle or
    // finishing; operands are captured at that same edge. done is a single
    // cycle pulse and the results stay stable afterwards until the next
    // operation completes.
    modport master (
        output start, is_signed, is_long, srca, srcb,
        input  busy, done, result_lo, result_hi, mul_nz, state
    );

    modport slave (
        input  start, is_signed, is_long, srca, srcb,
        output busy, done, result_lo, result_hi, mul_nz, state
    );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier for MUL, UMULL and SMULL.
// Signed operands are reduced to magnitudes, multiplied unsigned over WIDTH
// iterations, then the sign is re-applied in one extra cycle. busy and done
// are registered from the FSM state, so they trail the state by one cycle:
// done rises WIDTH+2 edges after the start edge.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    mul_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           st;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mcand;
    logic             neg;
    logic             long_op;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               accept;

    assign bus.state = st;

    // Operand magnitudes, the iteration adder and the sign-corrected product.
    always_comb begin
        abs_a  = bus.srca;
        abs_b  = bus.srcb;
        sum    = {1'b0, acc_hi};
        prod   = {acc_hi, mplier};
        accept = bus.start && (st == IDLE || st == DONE);
        if (bus.is_signed && bus.srca[WIDTH-1]) abs_a = -bus.srca;
        if (bus.is_signed && bus.srcb[WIDTH-1]) abs_b = -bus.srcb;
        if (mplier[0]) sum = {1'b0, acc_hi} + {1'b0, mcand};
        if (neg) prod = -{acc_hi, mplier};
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st            <= IDLE;
            count         <= '0;
            acc_hi        <= '0;
            mplier        <= '0;
            mcand         <= '0;
            neg           <= 1'b0;
            long_op       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result_lo <= '0;
            bus.result_hi <= '0;
            bus.mul_nz    <= 2'b00;
        end else begin
            bus.busy <= (st == RUN) || (st == SIGN);
            bus.done <= (st == DONE);
            case (st)
                IDLE, DONE: begin
                    if (accept) begin
                        neg     <= bus.is_signed & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                        long_op <= bus.is_long;
                        mcand   <= abs_a;
                        mplier  <= abs_b;
                        acc_hi  <= '0;
                        count   <= '0;
                        st      <= RUN;
                    end else begin
                        st <= IDLE;
                    end
                end
                RUN: begin
                    // {carry, acc_hi, mplier} shifts right by one.
                    acc_hi <= sum[WIDTH:1];
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) st <= SIGN;
                end
                SIGN: begin
                    bus.result_lo <= prod[WIDTH-1:0];
                    bus.result_hi <= prod[2*WIDTH-1:WIDTH];
                    if (long_op)
                        bus.mul_nz <= {prod[2*WIDTH-1], prod == '0};
                    else
                        bus.mul_nz <= {prod[WIDTH-1], prod[WIDTH-1:0] == '0};
                    st <= DONE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
